// File: rtl/fifo_banco_pkg.sv
// Shared constants and types for the four-lane elastic buffer (fifo_banco_4).
package fifo_banco_pkg;

    // Default lane geometry and thresholds
    localparam int unsigned DATA_WIDTH_DEF   = 8;
    localparam int unsigned DEPTH_DEF        = 8;
    localparam int unsigned ALMOST_FULL_DEF  = 6;
    localparam int unsigned ALMOST_EMPTY_DEF = 1;

    // Derived widths for the default depth
    localparam int unsigned PTR_W = $clog2(DEPTH_DEF);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Number of independent lanes in the bank
    localparam int unsigned NUM_LANES = 4;

    // What a lane does to its occupancy on a given edge
    typedef enum logic [1:0] {
        LANE_IDLE = 2'b00,
        LANE_PUSH = 2'b01,
        LANE_POP  = 2'b10,
        LANE_BOTH = 2'b11
    } lane_op_e;

    function automatic lane_op_e lane_op(input logic push_ok, input logic pop_ok);
        return lane_op_e'({pop_ok, push_ok});
    endfunction

endpackage

// File: rtl/fifo_carril.sv
// Single-lane FIFO: memory, pointers, occupancy count, status flags and the
// optional sticky overflow bit (built only when FIFO_BANCO_ERR_EN is defined).
module fifo_carril
    import fifo_banco_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH        = DEPTH_DEF,
    parameter int unsigned ALMOST_FULL  = ALMOST_FULL_DEF,
    parameter int unsigned ALMOST_EMPTY = ALMOST_EMPTY_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  error_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(ALMOST_FULL);
    localparam logic [CW-1:0] CNT_AE   = CW'(ALMOST_EMPTY);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  pop_ok, push_ok;
    lane_op_e              op;

    // A pop needs stored data; a push needs room, or a slot freed by a same-cycle pop.
    // No write-to-read bypass: on an empty lane only the push is taken.
    assign pop_ok  = pop_i && (cnt_q != '0);
    assign push_ok = push_i && ((cnt_q != CNT_FULL) || pop_ok);
    assign op      = lane_op(push_ok, pop_ok);

    // Next-state for pointers, count and the registered read port
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            data_d   = mem_q[rd_ptr_q];
            valid_d  = 1'b1;
        end
        case (op)
            LANE_PUSH: cnt_d = cnt_q + CW'(1);
            LANE_POP:  cnt_d = cnt_q - CW'(1);
            default:   cnt_d = cnt_q;
        endcase
    end

    // Lane state registers; reset discards all stored data at once
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o         = data_q;
    assign valid_o        = valid_q;
    assign full_o         = (cnt_q == CNT_FULL);
    assign empty_o        = (cnt_q == '0);
    assign almost_full_o  = (cnt_q >= CNT_AF);
    assign almost_empty_o = (cnt_q <= CNT_AE);

`ifdef FIFO_BANCO_ERR_EN
    logic err_q, err_d;

    assign err_d = err_q | (push_i & ~push_ok);

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: rtl/fifo_banco_4.sv
// Four-lane elastic buffer downstream of the recirculator: one independent
// FIFO per lane plus an aggregate pause flag. Optional macro FIFO_BANCO_ERR_EN
// enables the sticky per-lane overflow flags on `error`.
module fifo_banco_4
    import fifo_banco_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH        = DEPTH_DEF,
    parameter int unsigned ALMOST_FULL  = ALMOST_FULL_DEF,
    parameter int unsigned ALMOST_EMPTY = ALMOST_EMPTY_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic [DATA_WIDTH-1:0] data_in3,
    input  logic                  valid_in0,
    input  logic                  valid_in1,
    input  logic                  valid_in2,
    input  logic                  valid_in3,
    input  logic                  pop0,
    input  logic                  pop1,
    input  logic                  pop2,
    input  logic                  pop3,
    output logic [DATA_WIDTH-1:0] data_out0,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic [DATA_WIDTH-1:0] data_out2,
    output logic [DATA_WIDTH-1:0] data_out3,
    output logic                  valid_out0,
    output logic                  valid_out1,
    output logic                  valid_out2,
    output logic                  valid_out3,
    output logic [NUM_LANES-1:0]  full,
    output logic [NUM_LANES-1:0]  empty,
    output logic [NUM_LANES-1:0]  almost_full,
    output logic [NUM_LANES-1:0]  almost_empty,
    output logic                  pause,
    output logic [NUM_LANES-1:0]  error
);

    logic [DATA_WIDTH-1:0] din  [NUM_LANES];
    logic [DATA_WIDTH-1:0] dout [NUM_LANES];
    logic [NUM_LANES-1:0]  vin, popv, vout;

    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign din[2] = data_in2;
    assign din[3] = data_in3;
    assign vin    = {valid_in3, valid_in2, valid_in1, valid_in0};
    assign popv   = {pop3, pop2, pop1, pop0};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        fifo_carril #(
            .DATA_WIDTH  (DATA_WIDTH),
            .DEPTH       (DEPTH),
            .ALMOST_FULL (ALMOST_FULL),
            .ALMOST_EMPTY(ALMOST_EMPTY)
        ) u_carril (
            .clk_i         (clk),
            .rst_i         (reset),
            .data_i        (din[g]),
            .push_i        (vin[g]),
            .pop_i         (popv[g]),
            .data_o        (dout[g]),
            .valid_o       (vout[g]),
            .full_o        (full[g]),
            .empty_o       (empty[g]),
            .almost_full_o (almost_full[g]),
            .almost_empty_o(almost_empty[g]),
            .error_o       (error[g])
        );
    end

    assign data_out0  = dout[0];
    assign data_out1  = dout[1];
    assign data_out2  = dout[2];
    assign data_out3  = dout[3];
    assign valid_out0 = vout[0];
    assign valid_out1 = vout[1];
    assign valid_out2 = vout[2];
    assign valid_out3 = vout[3];

    assign pause = |almost_full;

endmodule

// File: tb/tb_fifo_banco_4.sv
// Scoreboard bench for fifo_banco_4: pushes queue expected words per lane,
// a negedge monitor compares valid_out/data_out against them.
module tb_fifo_banco_4;

    logic       clk, reset;
    logic [7:0] data_in0, data_in1, data_in2, data_in3;
    logic       valid_in0, valid_in1, valid_in2, valid_in3;
    logic       pop0, pop1, pop2, pop3;
    logic [7:0] data_out0, data_out1, data_out2, data_out3;
    logic       valid_out0, valid_out1, valid_out2, valid_out3;
    logic [3:0] full, empty, almost_full, almost_empty, error;
    logic       pause;

`ifdef FIFO_BANCO_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    fifo_banco_4 #(
        .DATA_WIDTH  (8),
        .DEPTH       (8),
        .ALMOST_FULL (6),
        .ALMOST_EMPTY(1)
    ) dut (
        .clk(clk), .reset(reset),
        .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
        .valid_in0(valid_in0), .valid_in1(valid_in1), .valid_in2(valid_in2), .valid_in3(valid_in3),
        .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
        .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
        .valid_out0(valid_out0), .valid_out1(valid_out1), .valid_out2(valid_out2), .valid_out3(valid_out3),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .pause(pause), .error(error)
    );

    logic [7:0] dout [4];
    logic [3:0] vout;
    assign dout[0] = data_out0;
    assign dout[1] = data_out1;
    assign dout[2] = data_out2;
    assign dout[3] = data_out3;
    assign vout    = {valid_out3, valid_out2, valid_out1, valid_out0};

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] expq [4][$];
    int         mcnt [4];
    logic [3:0] exp_pop = 4'b0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the reference model decides acceptance and queues expected data
    task automatic do_cycle(input logic [3:0] push, input logic [31:0] dat, input logic [3:0] pop);
        logic [3:0] nxt;
        logic       pop_ok, push_ok;
        for (int l = 0; l < 4; l++) begin
            pop_ok  = pop[l] && (mcnt[l] > 0);
            push_ok = push[l] && ((mcnt[l] < 8) || pop_ok);
            if (push_ok) begin
                expq[l].push_back(dat[8*l +: 8]);
                mcnt[l] = mcnt[l] + 1;
            end
            if (pop_ok) mcnt[l] = mcnt[l] - 1;
            nxt[l] = pop_ok;
        end
        data_in0 = dat[7:0];   data_in1 = dat[15:8];
        data_in2 = dat[23:16]; data_in3 = dat[31:24];
        {valid_in3, valid_in2, valid_in1, valid_in0} = push;
        {pop3, pop2, pop1, pop0} = pop;
        @(posedge clk);
        exp_pop = nxt;
        #1;
        {valid_in3, valid_in2, valid_in1, valid_in0} = 4'b0000;
        {pop3, pop2, pop1, pop0} = 4'b0000;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " empty"}, 32'(empty), 32'hF);
        check({tag, " almost_empty"}, 32'(almost_empty), 32'hF);
        check({tag, " full"}, 32'(full), 32'h0);
        check({tag, " almost_full"}, 32'(almost_full), 32'h0);
        check({tag, " pause"}, 32'(pause), 32'h0);
        check({tag, " error"}, 32'(error), 32'h0);
        check({tag, " valid_out"}, 32'(vout), 32'h0);
        check({tag, " data_out"}, {data_out3, data_out2, data_out1, data_out0}, 32'h0);
    endtask

    // Monitor: every word presented on a lane must be the oldest expected word
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (!reset) begin
            for (int l = 0; l < 4; l++) begin
                n_tests++;
                if (vout[l] !== exp_pop[l]) begin
                    n_fail++;
                    $display("FAIL valid_out%0d: got %b expected %b", l, vout[l], exp_pop[l]);
                end
                if (exp_pop[l]) begin
                    n_tests++;
                    if (expq[l].size() == 0) begin
                        n_fail++;
                        $display("FAIL data_out%0d: got %0h expected no word queued", l, dout[l]);
                    end else begin
                        e = expq[l].pop_front();
                        if (dout[l] !== e) begin
                            n_fail++;
                            $display("FAIL data_out%0d: got %0h expected %0h", l, dout[l], e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        for (int l = 0; l < 4; l++) mcnt[l] = 0;
        data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;
        {valid_in3, valid_in2, valid_in1, valid_in0} = 4'b0000;
        {pop3, pop2, pop1, pop0} = 4'b0000;

        // Reset with no clock edge yet
        reset = 1'b1;
        #2;
        check_reset_state("reset");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Per-lane ordering
        do_cycle(4'hF, 32'hCCDDEEFF, 4'h0);
        do_cycle(4'hF, 32'h8899AABB, 4'h0);
        check("order empty", 32'(empty), 32'h0);
        check("order almost_empty", 32'(almost_empty), 32'h0);
        do_cycle(4'h0, 32'h0, 4'hF);
        do_cycle(4'h0, 32'h0, 4'hF);
        check("order empty after", 32'(empty), 32'hF);
        do_cycle(4'h0, 32'h0, 4'h0);

        // Fill and overflow lane 0
        for (int k = 1; k <= 8; k++) begin
            do_cycle(4'h1, 32'(k), 4'h0);
            check($sformatf("fill%0d almost_full0", k), 32'(almost_full[0]), 32'(k >= 6));
            check($sformatf("fill%0d pause", k), 32'(pause), 32'(k >= 6));
            check($sformatf("fill%0d full0", k), 32'(full[0]), 32'(k == 8));
        end
        do_cycle(4'h1, 32'h77, 4'h0);
        check("overflow full0", 32'(full[0]), 32'h1);
        check("overflow error0", 32'(error[0]), 32'(ERR_ON));
        for (int k = 1; k <= 8; k++) begin
            do_cycle(4'h0, 32'h0, 4'h1);
            check($sformatf("drain%0d pause", k), 32'(pause), 32'((8 - k) >= 6));
        end
        check("drain empty0", 32'(empty[0]), 32'h1);
        check("drain error0 sticky", 32'(error[0]), 32'(ERR_ON));

        // Lane 1 full with simultaneous push and pop
        for (int k = 0; k < 8; k++) do_cycle(4'h2, 32'(8'h10 + k) << 8, 4'h0);
        check("lane1 full", 32'(full[1]), 32'h1);
        do_cycle(4'h2, 32'h00005500, 4'h2);
        check("lane1 both full", 32'(full[1]), 32'h1);
        check("lane1 both error", 32'(error[1]), 32'h0);
        for (int k = 0; k < 8; k++) do_cycle(4'h0, 32'h0, 4'h2);
        check("lane1 drained", 32'(empty[1]), 32'h1);

        // Empty lane 2 with simultaneous push and pop
        do_cycle(4'h4, 32'h00770000, 4'h4);
        check("lane2 data hold", 32'(data_out2), 32'h99);
        check("lane2 empty", 32'(empty[2]), 32'h0);
        check("lane2 almost_empty", 32'(almost_empty[2]), 32'h1);
        do_cycle(4'h0, 32'h0, 4'h4);
        do_cycle(4'h0, 32'h0, 4'h0);

        // Mid-stream asynchronous reset
        do_cycle(4'hF, 32'h44332211, 4'h0);
        do_cycle(4'hF, 32'h88776655, 4'h0);
        do_cycle(4'hF, 32'hCCBBAA99, 4'h0);
        do_cycle(4'h0, 32'h0, 4'hF);
        {pop3, pop2, pop1, pop0} = 4'hF;
        #2 reset = 1'b1;
        #1;
        check_reset_state("midreset");
        for (int l = 0; l < 4; l++) begin
            expq[l].delete();
            mcnt[l] = 0;
        end
        exp_pop = 4'b0000;
        reset = 1'b0;
        do_cycle(4'h0, 32'h0, 4'hF);
        do_cycle(4'h0, 32'h0, 4'hF);
        check("post reset data_out", {data_out3, data_out2, data_out1, data_out0}, 32'h0);
        check("post reset empty", 32'(empty), 32'hF);
        do_cycle(4'h0, 32'h0, 4'h0);

        for (int l = 0; l < 4; l++) check($sformatf("leftover lane%0d", l), 32'(expq[l].size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_banco_4.md
# fifo_banco_4

Four-lane elastic buffer that sits directly downstream of the recirculator. It absorbs the forwarded lane outputs (lanes 4-7 of the recirculator) into one independent FIFO per lane and releases bytes on per-lane pop requests. It produces an aggregate `pause` back-pressure flag so the traffic source can stop before any lane overflows.

## Interface
- `DATA_WIDTH`, 8: width of each lane word.
- `DEPTH`, 8: entries per lane; power of two, at least 4.
- `ALMOST_FULL`, 6: occupancy at or above which a lane is almost full.
- `ALMOST_EMPTY`, 1: occupancy at or below which a lane is almost empty.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `data_in0..3`, in, DATA_WIDTH each: lane write data, fed from recirculator `dataOut4..7`.
- `valid_in0..3`, in, 1 each: lane push request, fed from `validOut4..7`.
- `pop0..3`, in, 1 each: lane read request.
- `data_out0..3`, out, DATA_WIDTH each: registered read data.
- `valid_out0..3`, out, 1 each: the matching `data_out` holds a freshly popped word this cycle.
- `full`, out, 4: bit i means lane i count equals DEPTH.
- `empty`, out, 4: bit i means lane i count equals 0.
- `almost_full`, out, 4: bit i means lane i count is at least ALMOST_FULL.
- `almost_empty`, out, 4: bit i means lane i count is at most ALMOST_EMPTY.
- `pause`, out, 1: OR of all `almost_full` bits.
- `error`, out, 4: sticky per-lane overflow flag.

## Operation
- Each lane is independent. Each lane has a write pointer, a read pointer (both $clog2(DEPTH) bits, wrap modulo DEPTH) and a count ($clog2(DEPTH)+1 bits).
- A push is accepted when `valid_in`=1 and either (count<DEPTH) or (a pop is accepted in the same cycle). An accepted push writes `data_in` at `wr_ptr`, then `wr_ptr` increments.
- A pop is accepted when `pop`=1 and count>0 before the edge. There is no write-to-read bypass: push and pop on an empty lane accepts only the push.
- Count update:
  - +1 for push only.
  - −1 for pop only.
  - unchanged for both or neither.
- A push refused while full drops the data. The pointers and count stay unchanged, and the lane's `error` bit is set (see Configuration).
- A pop on an empty lane is ignored: pointers and count unchanged, `valid_out`=0, `data_out` holds its value.
- `full`, `empty`, `almost_full`, `almost_empty` and `pause` are combinational decodes of the registered counts.
- Reset values:
  - all pointers, counts, `data_out*` and `valid_out*` are 0;
  - `error` is 0, `empty` is 4'b1111, `almost_empty` is 4'b1111;
  - `full`, `almost_full` and `pause` are 0.
  - Memory contents are not reset.
- Reset asserted mid-operation discards all stored data immediately, regardless of the clock.

## Timing
- Write latency: a word pushed at edge N can be popped at edge N+1 at the earliest.
- Read latency: a pop accepted at edge N drives `data_out`/`valid_out` after edge N, valid for exactly one cycle unless popped again.
- Back-to-back pops stream one word per cycle. `valid_out` stays high continuously while words remain.
- `pause` rises in the cycle after the push that brings any lane's count to ALMOST_FULL. It falls in the cycle after the pop that drops every lane below ALMOST_FULL.
- Flags settle in the same cycle as the count update; they have no extra register stage.

## Configuration
- `FIFO_BANCO_ERR_EN` defined:
  - `error[i]` sets on a refused push to lane i.
  - It stays set until `reset`.
- `FIFO_BANCO_ERR_EN` undefined:
  - `error` is tied to 4'b0000 and no sticky register is built.
  - Overflowing pushes are still dropped silently.

## Structure
- Shared package `fifo_banco_pkg` holds:
  - default DATA_WIDTH, DEPTH, ALMOST_FULL and ALMOST_EMPTY;
  - the derived `PTR_W` = $clog2(DEPTH) and `CNT_W` = PTR_W+1;
  - the lane-count localparam 4.
- One sub-module, `fifo_carril`: a single-lane FIFO holding memory, pointers, count, flags and the optional error bit. It is instantiated four times.
- The top level only wires the lanes and ORs the `almost_full` bits into `pause`.

## Test plan
- Reset check: assert `reset` with no clock edges → `empty`=1111, `almost_empty`=1111, `pause`=0, `valid_out*`=0, `error`=0.
- Per-lane ordering:
  - Cycle 1: push FF/EE/DD/CC on lanes 0-3.
  - Cycle 2: push BB/AA/99/88.
  - Then pop all lanes for two cycles.
  - Expect `data_out`= FF,EE,DD,CC then BB,AA,99,88, with `valid_out`=1 for two cycles, and `empty`=1111 afterwards.
- Fill and overflow:
  - Push 8 words 01..08 on lane 0 → `almost_full[0]`=1 after the sixth word, `pause`=1, `full[0]`=1 after the eighth.
  - A ninth push of 77 → count stays 8 and `error[0]`=1 (0 without the macro).
  - Pops then return 01..08.
- Full-lane simultaneous event: with lane 1 full, push 55 and pop in the same cycle → pop returns the oldest word, count stays 8, 55 becomes the last word, `error[1]` stays 0.
- Empty-lane simultaneous event: push 77 and pop on empty lane 2 → `valid_out2`=0 that cycle, count becomes 1, and the next pop returns 77.
- Mid-stream reset: with lanes partially full and pops active, pulse `reset` between clock edges → all outputs return to reset values at once, and subsequent pops are ignored.
